// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared constants and FSM encodings for the pipeline hazard logic.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

  localparam int DATA_LEN   = 32;
  localparam int REG_ADDR_W = 5;

  // add x0,x0,x0 -- loaded into IF/ID when it is flushed
  localparam logic [DATA_LEN-1:0] NOP_INST = 32'h0000_0033;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } hz_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Event counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush sequencer for the 5-stage pipeline (freeze > flush > load-use).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  parameter int MAX_FREEZE = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_stall_i,
  output logic                  pc_write_o,
  output logic                  ifid_stall_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  data_stall_o,
  output logic                  freeze_err_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      freeze_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam int                   c_FCTR_W   = $clog2(MAX_FREEZE + 1);
  localparam logic [c_FCTR_W-1:0]  c_FCTR_MAX = c_FCTR_W'(MAX_FREEZE);

  hz_state_e           r_state, w_state_next;
  logic                r_flush_pend, w_flush_pend_next;
  logic [c_FCTR_W-1:0] r_freeze_ctr, w_freeze_ctr_next;
  logic                r_freeze_err;
  logic                w_luh, w_flush, w_stall;

  assign w_luh = ex_memread_i && (ex_rd_i != '0) &&
                 ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  always_comb begin
    w_state_next      = r_state;
    w_flush_pend_next = r_flush_pend;
    pc_write_o        = 1'b0;
    ifid_stall_o      = 1'b0;
    ifid_flush_o      = 1'b0;
    idex_bubble_o     = 1'b0;
    data_stall_o      = 1'b0;
    w_flush           = 1'b0;
    w_stall           = 1'b0;

    case (r_state)
      RUN:     if (mem_stall_i)  w_state_next = FREEZE;
      FREEZE:  if (!mem_stall_i) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase

    if (rst_i) begin
      w_state_next      = RUN;
      w_flush_pend_next = 1'b0;
    end else if (mem_stall_i) begin
      data_stall_o = 1'b1;
      if (branch_taken_i) w_flush_pend_next = 1'b1;
    end else if (r_flush_pend || (branch_taken_i && !w_luh)) begin
      // a branch seen alongside a load-use hazard used stale operands; it re-resolves next cycle
      ifid_flush_o      = 1'b1;
      pc_write_o        = 1'b1;
      w_flush           = 1'b1;
      w_flush_pend_next = 1'b0;
    end else if (w_luh) begin
      ifid_stall_o  = 1'b1;
      idex_bubble_o = 1'b1;
      w_stall       = 1'b1;
    end else begin
      pc_write_o = 1'b1;
    end
  end

  always_comb begin
    w_freeze_ctr_next = '0;
    if (w_state_next == FREEZE) begin
      w_freeze_ctr_next = (r_freeze_ctr == c_FCTR_MAX) ? r_freeze_ctr : r_freeze_ctr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= RUN;
      r_flush_pend <= 1'b0;
      r_freeze_ctr <= '0;
      r_freeze_err <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_flush_pend <= w_flush_pend_next;
      r_freeze_ctr <= w_freeze_ctr_next;
      if (w_freeze_ctr_next == c_FCTR_MAX) r_freeze_err <= 1'b1;
    end
  end

  assign freeze_err_o = r_freeze_err;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (w_stall),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (data_stall_o),
    .cnt_o (freeze_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (w_flush),
    .cnt_o (flush_cnt_o)
  );

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the control inputs of the IF/ID pipe register (stall, flush, data-stall freeze), the PC write enable and the ID/EX bubble.
- Resolves three hazard sources with fixed priority: memory freeze, then taken-branch flush, then load-use stall.
- Defers flushes that arrive during a freeze, keeps a freeze watchdog, and keeps saturating performance counters.

Parameters:
- REG_ADDR_W, 5, register-file address width
- CNT_W, 32, width of performance counters
- MAX_FREEZE, 1023, freeze cycles tolerated before the watchdog error is raised

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; synchronous, active-high
- id_rs1_i  in  REG_ADDR_W  rs1 of the instruction in ID
- id_rs2_i  in  REG_ADDR_W  rs2 of the instruction in ID
- ex_memread_i  in  1  instruction in EX is a load
- ex_rd_i  in  REG_ADDR_W  destination register of the instruction in EX
- branch_taken_i  in  1  branch/jump resolved taken in ID this cycle
- mem_stall_i  in  1  data memory busy; whole pipeline must hold
- pc_write_o  out  1  PC update enable
- ifid_stall_o  out  1  IF/ID hold
- ifid_flush_o  out  1  IF/ID load NOP
- idex_bubble_o  out  1  ID/EX controls zeroed
- data_stall_o  out  1  global freeze to every pipe register
- freeze_err_o  out  1  sticky watchdog error
- stall_cnt_o  out  CNT_W  load-use stall cycles
- freeze_cnt_o  out  CNT_W  memory freeze cycles
- flush_cnt_o  out  CNT_W  flushes issued

Behaviour:
- FSM states and transitions:
  - RUN -> FREEZE when mem_stall_i=1.
  - FREEZE -> RUN on the first cycle with mem_stall_i=0.
- Registered state: the FSM state, flush_pend, freeze_ctr, freeze_err_o and the three counters.
- Control outputs are combinational from inputs and registered state, with zero cycles of latency, so the pipe registers act in the same cycle.
- Load-use hazard: luh = ex_memread_i & (ex_rd_i!=0) & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i).
- Output priority each cycle:
  1. mem_stall_i=1:
     - data_stall_o=1, pc_write_o=0, all other control outputs 0.
     - If branch_taken_i=1, set flush_pend.
  2. Else, flush_pend=1 or branch_taken_i=1 (qualified: a branch coinciding with luh is ignored, because the ID operands are stale and the branch re-resolves next cycle):
     - ifid_flush_o=1, pc_write_o=1.
     - flush_pend clears.
     - flush_cnt +1.
  3. Else, luh=1:
     - ifid_stall_o=1, idex_bubble_o=1, pc_write_o=0.
     - stall_cnt +1.
  4. Else: pc_write_o=1, all other control outputs 0.
- A pending flush is issued on the first non-frozen cycle after FREEZE exits, even if branch_taken_i=0 in that cycle.
- A pending flush has priority over luh in that cycle.
- freeze_ctr:
  - Increments each cycle in FREEZE.
  - Resets to 0 on entering RUN.
  - When it reaches MAX_FREEZE, freeze_err_o is set and stays set until rst_i.
- freeze_cnt +1 per cycle with mem_stall_i=1.
- Counters saturate at all-ones and do not wrap.
- ifid_stall_o and ifid_flush_o are never 1 in the same cycle.
- data_stall_o=1 excludes every other control output.
- Reset:
  - Reset values: state RUN, flush_pend 0, freeze_ctr 0, all counters 0, freeze_err_o 0.
  - While rst_i=1, all control outputs are 0 (pc_write_o=0).
  - Asserting rst_i mid-freeze drops the pending flush; the first cycle after reset is a normal RUN cycle.

Decomposition:
- Shared package (Define.v) holds:
  - DATA_LEN
  - REG_ADDR_W
  - NOP_INST = 32'h00000033 (add x0,x0,x0), used by IF/ID on flush
  - FSM state encodings RUN=1'b0, FREEZE=1'b1
- One natural sub-module, sat_counter (param CNT_W; en, clr), instantiated three times for the counters.

Test Plan:
- ex_memread=1, ex_rd=5, id_rs1=5, one cycle -> ifid_stall=1, idex_bubble=1, pc_write=0; next cycle with ex_memread=0, pc_write=1; stall_cnt=1.
- ex_memread=1, ex_rd=0, id_rs2=0 -> no stall, pc_write=1.
- branch_taken=1 while mem_stall=1 for 4 cycles -> data_stall=1 for 4 cycles, ifid_flush=0 throughout; on cycle 5 (mem_stall=0, branch_taken=0) ifid_flush=1 for exactly one cycle; freeze_cnt=4, flush_cnt=1.
- branch_taken=1 together with luh=1 -> ifid_stall=1, ifid_flush=0; next cycle branch_taken=1, luh=0 -> ifid_flush=1.
- MAX_FREEZE=8, mem_stall held 10 cycles -> freeze_err_o rises on freeze cycle 8 and remains 1 after mem_stall drops, until rst_i.
- rst_i asserted during a freeze with flush_pend set -> all counters 0 and no flush in the first post-reset cycle; CNT_W=4 with 20 load-use cycles -> stall_cnt holds at 15.
